// File: rtl/video_timing_pkg.sv
// Raster timing constants for the video peripheral: default 1024x768@60 (64 MHz pixel clock)
// and 640x480@60 (25.175 MHz), with derived line/frame totals.
package video_timing_pkg;

  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_H_FP     = 24;
  localparam int XGA_H_SYNC   = 136;
  localparam int XGA_H_BP     = 160;
  localparam int XGA_V_ACTIVE = 768;
  localparam int XGA_V_FP     = 3;
  localparam int XGA_V_SYNC   = 6;
  localparam int XGA_V_BP     = 29;
  localparam int XGA_H_TOTAL  = XGA_H_ACTIVE + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;
  localparam int XGA_V_TOTAL  = XGA_V_ACTIVE + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

endpackage

// File: rtl/timing_axis.sv
// One raster axis: wrapping counter plus active/sync window decode.
// Counter registered, decode combinational from the count; no backpressure.
module timing_axis #(
  parameter int ACTIVE = 1024,
  parameter int FP     = 24,
  parameter int SYNC   = 136,
  parameter int BP     = 160,
  parameter int W      = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         adv,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         active,
  output logic         sync_act
);

  localparam int TOTAL   = ACTIVE + FP + SYNC + BP;
  localparam int SYNC_LO = ACTIVE + FP;
  localparam int SYNC_HI = ACTIVE + FP + SYNC - 1;

  logic [W-1:0] cnt_q, cnt_d;
  logic         last;

  assign last = (cnt_q == W'(TOTAL - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (adv)
      cnt_d = last ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt      = cnt_q;
  assign wrap     = adv & last;
  assign active   = (cnt_q < W'(ACTIVE));
  assign sync_act = (cnt_q >= W'(SYNC_LO)) && (cnt_q <= W'(SYNC_HI));

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: coordinates, visible, syncs, line/frame/vblank pulses, frame counter.
// Outputs registered-state decode (1 clk from enable to first pixel); free-running, no backpressure.
module vga_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = XGA_H_ACTIVE,
  parameter int H_FP     = XGA_H_FP,
  parameter int H_SYNC   = XGA_H_SYNC,
  parameter int H_BP     = XGA_H_BP,
  parameter int V_ACTIVE = XGA_V_ACTIVE,
  parameter int V_FP     = XGA_V_FP,
  parameter int V_SYNC   = XGA_V_SYNC,
  parameter int V_BP     = XGA_V_BP,
  parameter int PIX_DIV  = 1,
  parameter int HW       = 11,
  parameter int VW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          polarity,
  output logic [HW-1:0] pix_x,
  output logic [VW-1:0] pix_y,
  output logic          visible,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank_start,
  output logic [7:0]    frame_count
);

  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic          run_q, run_d;
  logic [DW-1:0] div_q, div_d;
  logic [7:0]    fc_q, fc_d;
  logic          div_wrap, clr, adv_h;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;
  logic          pulse_ok;

  assign div_wrap = (div_q == DW'(PIX_DIV - 1));
  // The first enabled edge only arms run, so the origin is shown for a full pixel.
  assign clr      = ~enable | ~run_q;
  assign adv_h    = run_q & enable & div_wrap;

  timing_axis #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(HW)
  ) u_h_axis (
    .clk(clk), .rst_n(rst_n), .clr(clr), .adv(adv_h),
    .cnt(h_cnt), .wrap(h_wrap), .active(h_act), .sync_act(h_sync)
  );

  timing_axis #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(VW)
  ) u_v_axis (
    .clk(clk), .rst_n(rst_n), .clr(clr), .adv(h_wrap),
    .cnt(v_cnt), .wrap(v_wrap), .active(v_act), .sync_act(v_sync)
  );

  always_comb begin
    run_d = enable;
    div_d = div_q;
    fc_d  = fc_q;
    if (clr)
      div_d = '0;
    else
      div_d = div_wrap ? '0 : div_q + DW'(1);
    if (v_wrap)
      fc_d = fc_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      div_q <= '0;
      fc_q  <= '0;
    end else begin
      run_q <= run_d;
      div_q <= div_d;
      fc_q  <= fc_d;
    end
  end

  assign pulse_ok = run_q && (div_q == '0) && (h_cnt == '0);

  assign pix_x        = run_q ? h_cnt : '0;
  assign pix_y        = run_q ? v_cnt : '0;
  assign visible      = run_q & h_act & v_act;
  assign hsync        = (run_q & h_sync) ^ ~polarity;
  assign vsync        = (run_q & v_sync) ^ ~polarity;
  assign line_start   = pulse_ok;
  assign frame_start  = pulse_ok && (v_cnt == '0);
  assign vblank_start = pulse_ok && (v_cnt == VW'(V_ACTIVE));
  // Frame count keeps its value while idle so software sees it across enable drops.
  assign frame_count  = fc_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator that feeds the sprite/background renderer in the TinyQV video peripheral. It produces pixel coordinates, the `visible` qualifier, hsync/vsync with selectable polarity, and one-cycle line/frame/vblank event pulses. It also keeps a free-running frame counter, which the renderer uses for the staging swap and the interrupt. Defaults give 1024x768@60 at a 64 MHz clk (1 pixel per clk).

## Interface

- `H_ACTIVE`, 1024, visible pixels per line
- `H_FP`, 24, horizontal front porch (pixels)
- `H_SYNC`, 136, hsync width (pixels)
- `H_BP`, 160, horizontal back porch (pixels)
- `V_ACTIVE`, 768, visible lines per frame
- `V_FP`, 3, vertical front porch (lines)
- `V_SYNC`, 6, vsync width (lines)
- `V_BP`, 29, vertical back porch (lines)
- `PIX_DIV`, 1, clk cycles per pixel (≥1)
- `HW`, 11, pix_x width; must hold H_TOTAL-1
- `VW`, 10, pix_y width; must hold V_TOTAL-1

Ports:

- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `enable`  in  1  run raster; 0 = hold at origin, outputs idle
- `polarity`  in  1  1 = syncs active-high, 0 = active-low
- `pix_x`  out  HW  horizontal counter
- `pix_y`  out  VW  vertical counter
- `visible`  out  1  pixel inside active area
- `hsync`  out  1  horizontal sync
- `vsync`  out  1  vertical sync
- `line_start`  out  1  pulse, first clk of h=0
- `frame_start`  out  1  pulse, first clk of h=0,v=0
- `vblank_start`  out  1  pulse, first clk of h=0,v=V_ACTIVE
- `frame_count`  out  8  completed-frame counter

## Operation

- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1344); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 806).
- State registers: `run`, `div_cnt` (0..PIX_DIV-1), `h`, `v`, `frame_count`.
- Reset: h=v=div_cnt=0, run=0, frame_count=0. All outputs then read 0, except the syncs, which sit at their inactive level (`~polarity`).
- `enable`=0 at any edge: h, v and div_cnt go to 0 and run goes to 0. frame_count holds.
- `enable`=1 with run=0: run goes to 1 and the counters stay at 0. The next cycle shows (0,0) with frame_start=1.
- `enable`=1 with run=1:
  - div_cnt advances and wraps at PIX_DIV-1.
  - On the wrap, h advances. h wraps H_TOTAL-1→0 and v then advances.
  - v wraps V_TOTAL-1→0 and frame_count then increments, wrapping 255→0.
- Outputs are decoded from the registered state. All outputs are gated by run.
  - `visible` = h<H_ACTIVE and v<V_ACTIVE.
  - `hsync` is active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - `vsync` is active for whole lines v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
  - Sync outputs = active XOR ~polarity.
  - Pulses require div_cnt=0 as well as their coordinate match.
- frame_count and frame_start change in the same cycle.
- A change of `polarity` takes effect immediately on both syncs.

## Timing

- Outputs are Moore, derived from registers; no combinational path from any input to any output except `polarity`→syncs.
- Latency from enable rising (sampled) to first visible pixel: 1 clk.
- Pixel rate is clk/PIX_DIV. Coordinates hold for PIX_DIV clks; pulses are exactly 1 clk.
- Line = H_TOTAL·PIX_DIV clks; frame = H_TOTAL·V_TOTAL·PIX_DIV clks (default 1,083,264).
- Mid-frame reset or enable drop: the raster restarts from (0,0) with no partial sync pulse carried over.

## Structure

- Package `video_timing_pkg`:
  - default 1024x768@64 MHz constants;
  - a 640x480@25.175 MHz set;
  - derived H_TOTAL/V_TOTAL localparams.
- Sub-module `timing_axis` (instantiated twice):
  - counter with advance input and wrap output;
  - active/sync window decode, parameterised by ACTIVE/FP/SYNC/BP.
- The top level holds run, div_cnt, the frame counter and the pulse logic.

## Test plan

Bench parameters unless stated: H 8/2/2/2 (H_TOTAL 14), V 4/1/1/1 (V_TOTAL 7), PIX_DIV 1, polarity 1.

1. Release reset with enable=1 → cycle 1: pix=(0,0), visible=1, frame_start=1, line_start=1, hsync=vsync=0; visible falls at pix_x=8; hsync=1 for pix_x 10..11.
2. Run 2 frames (196 clks) → frame_start every 98 clks; frame_count 0→1→2; vblank_start at (0,4); vsync=1 for all 14 clks of line 5.
3. Run PIX_DIV=3 → each coordinate held 3 clks; line_start 1 clk wide every 42 clks.
4. polarity=0 → syncs idle 1 and pulse 0 on the same cycles as scenario 1; reset value of both syncs = 1.
5. Drop enable at (6,2), raise 3 clks later → outputs idle while low; 1 clk after re-enable pix=(0,0) and frame_start=1; frame_count unchanged.
6. Force frame_count to 255 and complete a frame → frame_count wraps to 0 in the same cycle as frame_start. Also assert rst_n low mid-line → next cycle pix=(0,0), visible=0.
